parallel_to_serial_rf: RTL and testbench
========================================

Name: parallel_to_serial_rf

Overview:
- Downstream companion of the serial-to-parallel register file. Captures a packed vector of N_ELEMS words and emits the words one per transfer on a valid/ready stream, element 0 first.
- Used to re-serialise widened results before they are written into single-port SRAM or passed to a serial consumer.
- Back-to-back vectors stream with no bubble.

Parameters:
- WIDTH, 1: bits per element.
- N_ELEMS, 4: elements per vector. Must be at least 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset (see Behaviour).
- load  input  1  request to capture in.
- in  input  N_ELEMS*WIDTH  packed vector; element k is in[WIDTH*k +: WIDTH].
- load_ready  output  1  block can accept load this cycle.
- out_valid  output  1  out holds a valid element.
- out_ready  input  1  consumer accepts out this cycle.
- out  output  WIDTH  current element.
- idx  output  32  index of the current element.
- last  output  1  current element is index N_ELEMS-1.
- done  output  1  one-cycle pulse after the final element transfers.

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk.
  - On rst: state IDLE, idx=0, data=0, done=0.
  - Outputs after reset: out_valid=0, out=0, last=0, load_ready=1.
- States:
  - IDLE: out_valid=0, out=0, last=0.
  - STREAM: out_valid=1.
- Combinational outputs:
  - out = data[WIDTH*idx +: WIDTH] in STREAM, else 0.
  - last = STREAM & (idx == N_ELEMS-1).
  - xfer = out_valid & out_ready.
  - load_ready = IDLE | (last & out_ready).
- Load:
  - load & load_ready registers in into data, sets idx=0 and moves to STREAM on the next edge.
  - Latency is 1: load at cycle t gives out_valid=1 with element 0 at t+1.
  - load with load_ready=0 is ignored; data is not disturbed.
- Transfer:
  - On xfer with last=0: idx increments by 1.
  - On xfer with last=1, without a simultaneous accepted load: state goes to IDLE and idx goes to 0.
  - On xfer with last=1 and a simultaneous accepted load: new data is captured, idx=0 and state stays STREAM. There is no idle cycle between vectors.
- Stall: out_valid & !out_ready holds idx, out and data unchanged for any number of cycles.
- done: registered. It is 1 for exactly the cycle after each final-element xfer, including the back-to-back case.
- N_ELEMS=1: last=1 throughout STREAM. Each xfer completes a vector.
- Throughput: with out_ready held at 1 and load asserted whenever load_ready=1, the block sustains one element per cycle.
- Reset mid-stream: aborts the vector, returns to IDLE and gives no done pulse.
  - rst has priority over load and xfer in the same cycle.
- Width: idx is 32 bits. Index arithmetic never exceeds N_ELEMS-1.

Decomposition:
- Shared builtins package holds the state constants ST_IDLE=1'b0 and ST_STREAM=1'b1.
- idx is produced by the existing counter instance with MIN=0 and MAX=N_ELEMS-1:
  - en = xfer & !last.
  - clear = (xfer & last) | (load & load_ready).
- The FSM, data register and done register stay in this module.
- No further sub-modules.

Test Plan:
- WIDTH=8, N_ELEMS=4: load in=32'h44332211 with out_ready=1 -> out = 11, 22, 33, 44 on cycles t+1..t+4; last=1 only at t+4; done=1 at t+5 only; out_valid=0 at t+5.
- Same vector with out_ready low on cycles t+2..t+4 -> out stays 22 and idx stays 1 for those cycles; 33 and 44 follow when out_ready rises; exactly one done pulse.
- Back-to-back: second load 32'h88776655 asserted during the last=1 & out_ready cycle -> 44 is immediately followed by 55, with no out_valid gap; done pulses the cycle after 44 and again after 88.
- load asserted mid-stream while load_ready=0 with in=32'hFFFFFFFF -> the remaining elements are unchanged (33, 44).
- rst asserted at cycle t+2 of a stream -> from t+3: out_valid=0, idx=0, load_ready=1; no done pulse; a subsequent load streams from element 0.
- N_ELEMS=1, WIDTH=16: load 16'hABCD -> one cycle with out=ABCD and last=1; done pulse the next cycle; return to IDLE.

Source files
------------

// File: rtl/parallel_to_serial_rf_pkg.sv
// Shared constants and types for the parallel-to-serial register file.
package parallel_to_serial_rf_pkg;

  // FSM state encoding, kept as plain constants for legacy compatibility.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Element index type exposed on the idx port.
  typedef logic [31:0] idx_t;

  // Highest legal element index for a vector of n elements.
  function automatic idx_t last_index(input int n);
    return idx_t'(n - 1);
  endfunction

endpackage

// File: rtl/parallel_to_serial_rf_counter.sv
// Bounded up-counter: clears to MIN, steps by one on enable, wraps after MAX.
module parallel_to_serial_rf_counter
  import parallel_to_serial_rf_pkg::*;
#(
  parameter int MIN = 0,
  parameter int MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clear,
  output idx_t o_count
);

  idx_t r_count;

  // Clear wins over enable; the wrap keeps the count inside MIN..MAX.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= idx_t'(MIN);
    end else if (i_en) begin
      if (r_count == idx_t'(MAX)) begin
        r_count <= idx_t'(MIN);
      end else begin
        r_count <= r_count + idx_t'(1);
      end
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/parallel_to_serial_rf.sv
// Captures a packed vector of N_ELEMS words and streams them out one per
// valid/ready transfer, element 0 first, with no bubble between vectors.
module parallel_to_serial_rf
  import parallel_to_serial_rf_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int N_ELEMS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [N_ELEMS*WIDTH-1:0]   in,
  output logic                       load_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out,
  output logic [31:0]                idx,
  output logic                       last,
  output logic                       done
);

  logic [0:0]               r_state;
  logic [N_ELEMS*WIDTH-1:0] r_data;
  logic                     r_done;

  logic                     w_stream;
  logic                     w_last;
  logic                     w_xfer;
  logic                     w_load_ready;
  logic                     w_accept;
  logic [WIDTH-1:0]         w_out;
  logic [WIDTH-1:0]         w_elems [N_ELEMS];
  idx_t                     w_idx;

  assign w_stream     = (r_state == ST_STREAM);
  assign w_last       = w_stream && (w_idx == last_index(N_ELEMS));
  assign w_xfer       = w_stream && out_ready;
  assign w_load_ready = !w_stream || (w_last && out_ready);
  assign w_accept     = load && w_load_ready;

  // Element index; only advances on non-final transfers, so it never passes N_ELEMS-1.
  parallel_to_serial_rf_counter #(
    .MIN (0),
    .MAX (N_ELEMS - 1)
  ) u_idx_counter (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_xfer && !w_last),
    .i_clear ((w_xfer && w_last) || w_accept),
    .o_count (w_idx)
  );

  // Split the captured vector into its elements for the output mux.
  generate
    for (genvar gi = 0; gi < N_ELEMS; gi++) begin : g_elems
      assign w_elems[gi] = r_data[WIDTH*gi +: WIDTH];
    end
  endgenerate

  // Select the current element while streaming; drive zero when idle.
  always_comb begin
    w_out = '0;
    for (int k = 0; k < N_ELEMS; k++) begin
      if (w_stream && (w_idx == idx_t'(k))) begin
        w_out = w_elems[k];
      end
    end
  end

  // FSM: an accepted load always (re)enters STREAM, even on the final transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (w_accept) begin
      r_state <= ST_STREAM;
    end else if (w_xfer && w_last) begin
      r_state <= ST_IDLE;
    end
  end

  // Vector register; only written by an accepted load, so stalls and refused loads leave it intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (w_accept) begin
      r_data <= in;
    end
  end

  // One-cycle completion pulse following each final-element transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_xfer && w_last;
    end
  end

  assign load_ready = w_load_ready;
  assign out_valid  = w_stream;
  assign out        = w_out;
  assign idx        = w_idx;
  assign last       = w_last;
  assign done       = r_done;

endmodule

// File: tb/tb_parallel_to_serial_rf.sv
// Self-checking bench for parallel_to_serial_rf: a queue-based reference
// model for the 8x4 instance plus directed checks on a 16x1 instance.
module tb_parallel_to_serial_rf;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, N_ELEMS=4
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [N*W-1:0] in = '0;
  logic          out_ready = 1'b0;
  logic          load_ready, out_valid, last, done;
  logic [W-1:0]  out;
  logic [31:0]   idx;

  // Instance B: WIDTH=16, N_ELEMS=1
  logic          load_b = 1'b0;
  logic [15:0]   in_b = '0;
  logic          out_ready_b = 1'b0;
  logic          load_ready_b, out_valid_b, last_b, done_b;
  logic [15:0]   out_b;
  logic [31:0]   idx_b;

  parallel_to_serial_rf #(.WIDTH(W), .N_ELEMS(N)) dut_a (
    .clk(clk), .rst(rst), .load(load), .in(in), .load_ready(load_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .idx(idx),
    .last(last), .done(done)
  );

  parallel_to_serial_rf #(.WIDTH(16), .N_ELEMS(1)) dut_b (
    .clk(clk), .rst(rst), .load(load_b), .in(in_b), .load_ready(load_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out(out_b), .idx(idx_b),
    .last(last_b), .done(done_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of elements still to be emitted for the current vector.
  logic [W-1:0] q [$];
  bit           m_done = 1'b0;
  logic [43:0]  exp_vec;
  logic [43:0]  obs_vec;
  assign obs_vec = {out_valid, out, idx, last, load_ready, done};

  // Drive one cycle of inputs on the falling edge and form the expected outputs.
  task automatic apply(input logic ld, input logic [31:0] v, input logic ordy, input logic rs);
    bit           e_valid, e_last, e_lr;
    logic [W-1:0] e_out;
    logic [31:0]  e_idx;
    @(negedge clk);
    load = ld; in = v; out_ready = ordy; rst = rs;
    #1;
    e_valid = (q.size() > 0);
    e_last  = (q.size() == 1);
    e_out   = e_valid ? q[0] : 8'h00;
    e_idx   = e_valid ? 32'(N - q.size()) : 32'd0;
    e_lr    = !e_valid || (e_last && ordy);
    exp_vec = {e_valid, e_out, e_idx, e_last, e_lr, m_done};
  endtask

  // Advance the reference model across the rising edge.
  task automatic advance();
    bit v, lst, lr, x;
    @(posedge clk);
    v   = (q.size() > 0);
    lst = (q.size() == 1);
    lr  = !v || (lst && out_ready);
    x   = v && out_ready;
    if (rst) begin
      q.delete();
      m_done = 1'b0;
    end else begin
      m_done = x && lst;
      if (x) void'(q.pop_front());
      if (load && lr) begin
        for (int k = 0; k < N; k++) q.push_back(in[W*k +: W]);
      end
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, 32'h0, 1'b0, (c < 2));
      if (c > 0) begin
        n_cmp++;
        if (obs_vec !== 44'h0000_0000_0002) begin
          n_bad++;
          $display("FAIL reset cyc=%0d got=%h want=%h", c, obs_vec, 44'h0000_0000_0002);
        end
      end
      advance();
    end
  endtask

  task automatic test_basic();
    for (int c = 0; c < 7; c++) begin
      apply(c == 0, 32'h44332211, 1'b1, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL basic cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 9; c++) begin
      apply(c == 0, 32'h44332211, !(c >= 2 && c <= 4), 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL stall cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 11; c++) begin
      apply(c == 0 || c == 4, (c == 0) ? 32'h44332211 : 32'h88776655, 1'b1, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL back_to_back cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_ignored_load();
    for (int c = 0; c < 7; c++) begin
      apply(c == 0 || c == 2 || c == 3, (c == 0) ? 32'h44332211 : 32'hFFFFFFFF, 1'b1, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL ignored_load cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_mid_reset();
    for (int c = 0; c < 11; c++) begin
      apply(c == 0 || c == 2 || c == 4, (c == 4) ? 32'hDEADBEEF : 32'h44332211, 1'b1, c == 2);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL mid_reset cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      apply(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
            (c < 390) && ($urandom_range(0, 59) == 0));
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      advance();
    end
    for (int c = 0; c < N + 2; c++) begin
      apply(1'b0, 32'h0, 1'b1, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL random_drain cyc=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  // Single-element vectors: every transfer is a final one.
  task automatic test_single();
    bit          ld_t   [9] = '{1, 0, 0, 1, 1, 1, 0, 0, 0};
    logic [15:0] din_t  [9] = '{16'hABCD, 16'h0, 16'h0, 16'h1234, 16'h5678, 16'h5678, 16'h0, 16'h0, 16'h0};
    bit          rdy_t  [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
    // {valid, out, last, load_ready, done}
    logic [19:0] want_t [9] = '{
      {1'b0, 16'h0000, 1'b0, 1'b1, 1'b0},
      {1'b1, 16'hABCD, 1'b1, 1'b1, 1'b0},
      {1'b0, 16'h0000, 1'b0, 1'b1, 1'b1},
      {1'b0, 16'h0000, 1'b0, 1'b1, 1'b0},
      {1'b1, 16'h1234, 1'b1, 1'b0, 1'b0},
      {1'b1, 16'h1234, 1'b1, 1'b1, 1'b0},
      {1'b1, 16'h5678, 1'b1, 1'b1, 1'b1},
      {1'b0, 16'h0000, 1'b0, 1'b1, 1'b1},
      {1'b0, 16'h0000, 1'b0, 1'b1, 1'b0}
    };
    logic [19:0] got;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      load_b = ld_t[c]; in_b = din_t[c]; out_ready_b = rdy_t[c];
      #1;
      got = {out_valid_b, out_b, last_b, load_ready_b, done_b};
      n_cmp++;
      if (got !== want_t[c] || idx_b !== 32'd0) begin
        n_bad++;
        $display("FAIL single cyc=%0d got=%h idx=%0d want=%h idx=0", c, got, idx_b, want_t[c]);
      end
      @(posedge clk);
    end
    load_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_basic();
    test_stall();
    test_back_to_back();
    test_ignored_load();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
